// File: rtl/msdf_online_addsub.sv
// msdf_online_addsub
//   Radix-2 MSDF online adder/subtractor with its own frame controller.
//   Takes two N-digit signed-digit streams (one pair per accepted handshake)
//   and emits N+1 result digits z_0..z_N with online delay 2.
//
//   Digit encoding on all digit ports: 11 = -1, 00 = 0, 01 = +1 (10 read as 0).
//
//   Ports
//     clk, rst       clock, synchronous active-high reset
//     start, sub     begin a frame (IDLE only); sub selects X-Y
//     x_digit        operand X digit
//     y_digit        operand Y digit
//     in_valid       digit pair present
//     in_ready       high in RUN
//     z_digit        result digit
//     z_valid        one-cycle pulse per result digit
//     z_last         marks z_N
//     busy           high in RUN and DRAIN

module msdf_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module msdf_online_addsub #(
  parameter int N = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sub,
  input  logic [1:0] x_digit,
  input  logic [1:0] y_digit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [1:0] z_digit,
  output logic       z_valid,
  output logic       z_last,
  output logic       busy
);

  localparam int CW = $clog2(N + 3);
  localparam logic [CW-1:0] CNT_LAST_IN  = CW'(N - 1);
  localparam logic [CW-1:0] CNT_LAST_ADV = CW'(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            sub_q;
  logic            s1n_q;   // negative-weight level-1 sum bit, position t-1
  logic            yn_q;    // negative bit of y, position t-1
  logic            s2_q;    // level-2 sum bit, position t-2
  logic [1:0]      z_digit_q;
  logic            z_valid_q;
  logic            z_last_q;

  logic            adv;
  logic            clear;
  logic            xp, xn, yp_raw, yn_raw, yp, yn;
  logic            c1, s1, c2, s2;
  logic            z_pos, z_neg;
  logic [1:0]      z_enc;

  // ---------------------------------------------------------------- control
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (in_valid && cnt_q == CNT_LAST_IN) state_d = DRAIN;
      DRAIN:   if (cnt_q == CNT_LAST_ADV) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign adv   = (state_q == RUN && in_valid) || (state_q == DRAIN);
  assign clear = (state_q == IDLE) && start;

  // ---------------------------------------------------------------- datapath
  // Borrow-save view: each digit is (pos, neg) with value pos - neg.
  // Outside RUN the injected pair is zero (DRAIN flush digits).
  always_comb begin
    xp     = (state_q == RUN) && (x_digit == 2'b01);
    xn     = (state_q == RUN) && (x_digit == 2'b11);
    yp_raw = (state_q == RUN) && (y_digit == 2'b01);
    yn_raw = (state_q == RUN) && (y_digit == 2'b11);
    yp     = sub_q ? yn_raw : yp_raw;
    yn     = sub_q ? yp_raw : yn_raw;
  end

  // Level 1: xp + (1-xn) + yp = 2*c1 + s1, so xp - xn + yp = 2*c1 - ~s1.
  // c1 moves one position up (towards the digit already registered).
  msdf_fa u_fa_l1 (
    .a  (xp),
    .b  (~xn),
    .c  (yp),
    .s  (s1),
    .co (c1)
  );

  // Level 2 at position t-1 on its two negative bits and the incoming
  // positive c1: s1n + yn + (1-c1) = 2*c2 + s2, so the position value is
  // (1-s2) - 2*c2. Result digit z_j = ~s2_j - c2_{j+1}.
  msdf_fa u_fa_l2 (
    .a  (s1n_q),
    .b  (yn_q),
    .c  (~c1),
    .s  (s2),
    .co (c2)
  );

  assign z_pos = ~s2_q;
  assign z_neg = c2;

  always_comb begin
    z_enc = 2'b00;
    if (z_pos && !z_neg) z_enc = 2'b01;
    if (z_neg && !z_pos) z_enc = 2'b11;
  end

  // ---------------------------------------------------------------- registers
  // Cleared pipeline state equals a virtual zero digit pair at position 0,
  // which is what makes z_0 fall out of the same recurrence.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sub_q     <= 1'b0;
      s1n_q     <= 1'b0;
      yn_q      <= 1'b0;
      s2_q      <= 1'b0;
      z_digit_q <= '0;
      z_valid_q <= 1'b0;
      z_last_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      z_digit_q <= '0;
      z_valid_q <= 1'b0;
      z_last_q  <= 1'b0;
      if (clear) begin
        sub_q <= sub;
        cnt_q <= '0;
        s1n_q <= 1'b0;
        yn_q  <= 1'b0;
        s2_q  <= 1'b0;
      end else if (adv) begin
        cnt_q <= cnt_q + 1'b1;
        s1n_q <= ~s1;
        yn_q  <= yn;
        s2_q  <= s2;
        if (cnt_q != '0) begin
          z_valid_q <= 1'b1;
          z_digit_q <= z_enc;
          z_last_q  <= (cnt_q == CNT_LAST_ADV);
        end
      end
    end
  end

  assign in_ready = (state_q == RUN);
  assign busy     = (state_q != IDLE);
  assign z_digit  = z_digit_q;
  assign z_valid  = z_valid_q;
  assign z_last   = z_last_q;

endmodule

// File: tb/tb_msdf_online_addsub.sv
// tb_msdf_online_addsub
//   Drives directed and random frames into msdf_online_addsub (N=4) and
//   compares the weighted result digit sum against plain integer X+/-Y.

module tb_msdf_online_addsub;

  localparam int N = 4;
  localparam int ZW = 2 * (N + 1);

  typedef logic [1:0] dig_t;
  typedef dig_t       frame_t[N];
  typedef int         stall_t[N];

  localparam dig_t P  = 2'b01;
  localparam dig_t M  = 2'b11;
  localparam dig_t Z0 = 2'b00;
  localparam dig_t IL = 2'b10;

  logic       clk;
  logic       rst;
  logic       start;
  logic       sub;
  logic [1:0] x_digit;
  logic [1:0] y_digit;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] z_digit;
  logic       z_valid;
  logic       z_last;
  logic       busy;

  msdf_online_addsub #(.N(N)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .x_digit  (x_digit),
    .y_digit  (y_digit),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .z_digit  (z_digit),
    .z_valid  (z_valid),
    .z_last   (z_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // collected result of the most recent frame
  int           z_acc;
  int           z_cnt;
  int           z_ill;
  logic [ZW-1:0] z_seq;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int dval(input dig_t d);
    case (d)
      2'b01:   return 1;
      2'b11:   return -1;
      default: return 0;
    endcase
  endfunction

  // X scaled by 2^N
  function automatic int scaled(input frame_t d);
    int acc = 0;
    for (int j = 0; j < N; j++) acc = acc * 2 + dval(d[j]);
    return acc;
  endfunction

  task automatic collect();
    if (z_valid) begin
      z_acc = z_acc * 2 + dval(z_digit);
      if (z_digit == 2'b10) z_ill++;
      if (z_cnt < N + 1) z_seq[2*z_cnt +: 2] = z_digit;
      z_cnt++;
    end
  endtask

  task automatic run_frame(input logic s, input frame_t xs, input frame_t ys,
                           input stall_t stalls, input bit mid_start);
    int exp_z;
    exp_z = s ? scaled(xs) - scaled(ys) : scaled(xs) + scaled(ys);
    z_acc = 0; z_cnt = 0; z_ill = 0; z_seq = '0;

    start = 1'b1; sub = s; in_valid = 1'b0;
    tick();
    start = 1'b0; sub = ~s;
    check("ready_after_start", in_ready, 1);
    check("busy_after_start", busy, 1);

    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < stalls[i]; k++) begin
        in_valid = 1'b0;
        x_digit = dig_t'($urandom_range(0, 3));
        y_digit = dig_t'($urandom_range(0, 3));
        tick();
        check("stall_z_valid", z_valid, 0);
        check("stall_in_ready", in_ready, 1);
      end
      in_valid = 1'b1; x_digit = xs[i]; y_digit = ys[i];
      if (mid_start && i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      check("run_z_valid", z_valid, (i >= 1) ? 1 : 0);
      check("run_z_last", z_last, 0);
      collect();
    end

    // in_valid held high with junk during DRAIN must be ignored
    in_valid = 1'b1;
    x_digit = dig_t'($urandom_range(0, 3));
    y_digit = dig_t'($urandom_range(0, 3));
    tick();
    check("drain_in_ready", in_ready, 0);
    check("drain_busy", busy, 1);
    check("drain_z_valid", z_valid, 1);
    check("drain_z_last", z_last, 0);
    collect();
    tick();
    in_valid = 1'b0;
    check("last_z_valid", z_valid, 1);
    check("last_z_last", z_last, 1);
    check("last_busy", busy, 0);
    collect();

    check("z_sum", z_acc, exp_z);
    check("z_count", z_cnt, N + 1);
    check("z_illegal", z_ill, 0);
  endtask

  initial begin
    frame_t        xs, ys;
    stall_t        st0, st;
    logic [ZW-1:0] seq_ref;

    rst = 1'b1; start = 1'b0; sub = 1'b0;
    x_digit = '0; y_digit = '0; in_valid = 1'b0;
    st0 = '{0, 0, 0, 0};
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready", in_ready, 0);
    check("rst_z_digit", z_digit, 0);
    check("rst_z_valid", z_valid, 0);
    check("rst_z_last", z_last, 0);
    check("rst_busy", busy, 0);
    tick();

    xs = '{P, P, P, P}; ys = '{P, P, P, P};
    run_frame(1'b0, xs, ys, st0, 1'b0);
    check("pos_sum_30", z_acc, 30);
    seq_ref = z_seq;

    xs = '{M, M, M, M}; ys = '{M, M, M, M};
    run_frame(1'b0, xs, ys, st0, 1'b0);
    check("neg_sum_m30", z_acc, -30);

    xs = '{P, Z0, M, P}; ys = '{P, Z0, M, P};
    run_frame(1'b1, xs, ys, st0, 1'b0);
    check("sub_self_zero", z_acc, 0);

    xs = '{P, Z0, Z0, Z0}; ys = '{Z0, Z0, Z0, P};
    run_frame(1'b1, xs, ys, st0, 1'b0);
    check("sub_7", z_acc, 7);

    xs = '{P, P, P, P}; ys = '{P, P, P, P};
    st = '{0, 3, 0, 3};
    run_frame(1'b0, xs, ys, st, 1'b0);
    check("stalled_same_digits", (z_seq == seq_ref) ? 1 : 0, 1);

    // abort after two accepts
    start = 1'b1; sub = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; x_digit = P; y_digit = M;
      tick();
    end
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("abort_in_ready", in_ready, 0);
    check("abort_z_digit", z_digit, 0);
    check("abort_z_valid", z_valid, 0);
    check("abort_z_last", z_last, 0);
    check("abort_busy", busy, 0);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      tick();
      check("abort_quiet", z_valid, 0);
    end
    in_valid = 1'b0;
    xs = '{P, Z0, Z0, Z0}; ys = '{Z0, P, Z0, Z0};
    run_frame(1'b0, xs, ys, st0, 1'b0);
    check("after_abort_12", z_acc, 12);

    xs = '{IL, IL, IL, IL}; ys = '{P, P, P, P};
    run_frame(1'b0, xs, ys, st0, 1'b1);
    check("illegal_x_15", z_acc, 15);

    for (int f = 0; f < 40; f++) begin
      for (int j = 0; j < N; j++) begin
        xs[j] = dig_t'($urandom_range(0, 3));
        ys[j] = dig_t'($urandom_range(0, 3));
        st[j] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      if ($urandom_range(0, 1) == 1) tick();
      run_frame(1'($urandom_range(0, 1)), xs, ys, st, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
